// File: rtl/issue_sched.sv
// rtl/issue_sched.sv - in-order single-issue scheduler with register scoreboard and multi-cycle tracking
// Optional build macro ISSUE_SCHED_WB_BYPASS_EN: writeback clears the hazard bit in the same cycle.
module issue_sched #(
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_kind,
   input  logic [2:0]  in_cond,
   input  logic [4:0]  in_op,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rq,
   input  logic        in_wr,
   input  logic        flag_eq,
   input  logic        flag_lt,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   output logic        iss_valid,
   input  logic        iss_ready,
   output logic [2:0]  iss_kind,
   output logic [4:0]  iss_op,
   output logic [4:0]  iss_rd,
   output logic [4:0]  iss_rs,
   output logic [4:0]  iss_rq,
   output logic        iss_wr,
   output logic        busy,
   output logic        err,
   output logic [31:0] sb,
   output logic [15:0] drop_cnt
);

   typedef enum logic [2:0] {
      KIND_RRR     = 3'd0,
      KIND_RRI     = 3'd1,
      KIND_MEM     = 3'd2,
      KIND_BRANCH  = 3'd3,
      KIND_CUSTOM  = 3'd4,
      KIND_INVALID = 3'd7
   } e_kind;

   typedef enum logic [2:0] {
      COND_AL = 3'd0, COND_EQ = 3'd1, COND_NE = 3'd2, COND_GT = 3'd3,
      COND_GE = 3'd4, COND_LT = 3'd5, COND_LE = 3'd6, COND_NV = 3'd7
   } e_cond;

   typedef enum logic [4:0] {
      BINOP_ADD = 5'd0, BINOP_SUB = 5'd1, BINOP_MUL = 5'd2,
      BINOP_DIV = 5'd3, BINOP_MOD = 5'd4
   } e_bin_op;

   typedef enum logic [1:0] {IDLE, HOLD, MULTI} state_t;

   state_t      state, state_nxt;
   logic [2:0]  h_kind, h_cond;
   logic [4:0]  h_op, h_rd, h_rs, h_rq;
   logic        h_wr;
   logic        lock;
   logic [7:0]  cnt;
   logic [7:0]  lat_m1;
   logic        kind_bad, cond_ok, hazard, fire, drop_inc;
   logic [31:0] sb_chk, wb_mask, set_mask;

   assign in_ready = (state == IDLE) && !rst;
   assign busy     = (state == MULTI);
   assign iss_kind = h_kind;
   assign iss_op   = h_op;
   assign iss_rd   = h_rd;
   assign iss_rs   = h_rs;
   assign iss_rq   = h_rq;
   assign iss_wr   = h_wr;
   assign wb_mask  = wb_valid ? (32'd1 << wb_rd) : 32'd0;
   assign set_mask = (fire && h_wr) ? (32'd1 << h_rd) : 32'd0;

   always_comb begin
      kind_bad = (h_kind == KIND_INVALID) || (h_kind == 3'd5) || (h_kind == 3'd6);
      case (h_cond)
         COND_AL: cond_ok = 1'b1;
         COND_EQ: cond_ok = flag_eq;
         COND_NE: cond_ok = !flag_eq;
         COND_GT: cond_ok = !flag_eq && !flag_lt;
         COND_GE: cond_ok = !flag_lt;
         COND_LT: cond_ok = flag_lt;
         COND_LE: cond_ok = flag_lt || flag_eq;
         default: cond_ok = 1'b0;
      endcase
`ifdef ISSUE_SCHED_WB_BYPASS_EN
      sb_chk = sb & ~wb_mask;
`else
      sb_chk = sb;
`endif
      hazard = sb_chk[h_rs] || sb_chk[h_rq] || (h_wr && sb_chk[h_rd]);
      lat_m1 = 8'd0;
      if ((h_kind == KIND_RRR) || (h_kind == KIND_RRI)) begin
         if (h_op == BINOP_MUL)
            lat_m1 = 8'(MUL_LAT - 1);
         else if ((h_op == BINOP_DIV) || (h_op == BINOP_MOD))
            lat_m1 = 8'(DIV_LAT - 1);
      end
   end

   always_comb begin
      state_nxt = state;
      iss_valid = 1'b0;
      err       = 1'b0;
      fire      = 1'b0;
      drop_inc  = 1'b0;
      case (state)
         IDLE: if (in_valid && in_ready) state_nxt = HOLD;
         HOLD: begin
            if (kind_bad) begin
               err       = 1'b1;
               drop_inc  = 1'b1;
               state_nxt = IDLE;
            end else if (lock || (cond_ok && !hazard)) begin
               // once offered, the instruction is committed regardless of flags or scoreboard
               iss_valid = 1'b1;
               if (iss_ready) begin
                  fire      = 1'b1;
                  state_nxt = (lat_m1 == 8'd0) ? IDLE : MULTI;
               end
            end else if (!cond_ok) begin
               drop_inc  = 1'b1;
               state_nxt = IDLE;
            end
         end
         MULTI: if (cnt <= 8'd1) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         h_kind   <= 3'd0;
         h_cond   <= 3'd0;
         h_op     <= 5'd0;
         h_rd     <= 5'd0;
         h_rs     <= 5'd0;
         h_rq     <= 5'd0;
         h_wr     <= 1'b0;
         lock     <= 1'b0;
         cnt      <= 8'd0;
         sb       <= 32'd0;
         drop_cnt <= 16'd0;
      end else begin
         state <= state_nxt;
         if (in_valid && in_ready) begin
            h_kind <= in_kind;
            h_cond <= in_cond;
            h_op   <= in_op;
            h_rd   <= in_rd;
            h_rs   <= in_rs;
            h_rq   <= in_rq;
            h_wr   <= in_wr;
         end
         lock <= iss_valid && !iss_ready;
         if (fire)
            cnt <= lat_m1;
         else if ((state == MULTI) && (cnt != 8'd0))
            cnt <= cnt - 8'd1;
         // set applied after clear so a same-cycle issue keeps its pending bit
         sb <= (sb & ~wb_mask) | set_mask;
         if (drop_inc && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_issue_sched.sv
// tb/tb_issue_sched.sv - randomized and directed check of issue_sched against an instruction-level model
module tb_issue_sched;

   localparam int MUL_L = 3;
   localparam int DIV_L = 16;
`ifdef ISSUE_SCHED_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, in_valid, in_wr, flag_eq, flag_lt, wb_valid, iss_ready;
   logic [2:0]  in_kind, in_cond;
   logic [4:0]  in_op, in_rd, in_rs, in_rq, wb_rd;
   logic        in_ready, iss_valid, iss_wr, busy, err;
   logic [2:0]  iss_kind;
   logic [4:0]  iss_op, iss_rd, iss_rs, iss_rq;
   logic [31:0] sb;
   logic [15:0] drop_cnt;

   int total = 0;
   int bad = 0;

   // model state: one held instruction, a pending-write set, and the cycle at which execution ends
   int          cyc = 0;
   int          busy_end = 0;
   bit          m_hold = 0, m_offered = 0;
   logic [2:0]  mk, mc;
   logic [4:0]  mop, mrd, mrs, mrq;
   logic        mwr;
   logic [31:0] pend = 32'd0;
   logic [15:0] drops = 16'd0;

   always #5 clk = ~clk;

   issue_sched #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_kind(in_kind), .in_cond(in_cond), .in_op(in_op),
      .in_rd(in_rd), .in_rs(in_rs), .in_rq(in_rq), .in_wr(in_wr),
      .flag_eq(flag_eq), .flag_lt(flag_lt), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_kind(iss_kind), .iss_op(iss_op),
      .iss_rd(iss_rd), .iss_rs(iss_rs), .iss_rq(iss_rq), .iss_wr(iss_wr),
      .busy(busy), .err(err), .sb(sb), .drop_cnt(drop_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic bit blocked(input logic [4:0] r, input logic wv, input logic [4:0] wrd);
      return pend[r] && !(BYP && wv && (wrd == r));
   endfunction

   function automatic int latency(input logic [2:0] k, input logic [4:0] op);
      if (k <= 3'd1 && op == 5'd2) return MUL_L;
      if (k <= 3'd1 && (op == 5'd3 || op == 5'd4)) return DIV_L;
      return 1;
   endfunction

   task automatic step(input logic r, input logic iv, input logic [2:0] k, input logic [2:0] c,
                       input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rq, input logic wr, input logic eq, input logic lt,
                       input logic wv, input logic [4:0] wrd, input logic ir);
      bit m_busy, idle, kbad, cok, haz, exp_iv;
      logic [31:0] npend;
      @(negedge clk);
      rst = r; in_valid = iv; in_kind = k; in_cond = c; in_op = op;
      in_rd = rd; in_rs = rs; in_rq = rq; in_wr = wr; flag_eq = eq; flag_lt = lt;
      wb_valid = wv; wb_rd = wrd; iss_ready = ir;
      #1;
      if (r) begin
         check("rst_in_ready", 32'(in_ready), 32'd0);
         check("rst_iss_valid", 32'(iss_valid), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_err", 32'(err), 32'd0);
         check("rst_sb", sb, 32'd0);
         check("rst_drop", 32'(drop_cnt), 32'd0);
         m_hold = 0; m_offered = 0; busy_end = 0; cyc = 0; pend = 32'd0; drops = 16'd0;
         return;
      end
      m_busy = (cyc < busy_end);
      idle   = !m_hold && !m_busy;
      kbad   = m_hold && (mk == 3'd5 || mk == 3'd6 || mk == 3'd7);
      case (mc)
         3'd0: cok = 1;
         3'd1: cok = eq;
         3'd2: cok = !eq;
         3'd3: cok = !eq && !lt;
         3'd4: cok = !lt;
         3'd5: cok = lt;
         3'd6: cok = lt || eq;
         default: cok = 0;
      endcase
      haz    = blocked(mrs, wv, wrd) || blocked(mrq, wv, wrd) || (mwr && blocked(mrd, wv, wrd));
      exp_iv = m_hold && !kbad && (m_offered || (cok && !haz));
      check("in_ready", 32'(in_ready), 32'(idle));
      check("iss_valid", 32'(iss_valid), 32'(exp_iv));
      check("busy", 32'(busy), 32'(m_busy));
      check("err", 32'(err), 32'(kbad));
      check("sb", sb, pend);
      check("drop_cnt", 32'(drop_cnt), 32'(drops));
      if (exp_iv) begin
         check("iss_kind", 32'(iss_kind), 32'(mk));
         check("iss_op", 32'(iss_op), 32'(mop));
         check("iss_rd", 32'(iss_rd), 32'(mrd));
         check("iss_rs", 32'(iss_rs), 32'(mrs));
         check("iss_rq", 32'(iss_rq), 32'(mrq));
         check("iss_wr", 32'(iss_wr), 32'(mwr));
      end
      npend = pend;
      if (wv) npend[wrd] = 1'b0;
      if (idle && iv) begin
         m_hold = 1; m_offered = 0;
         mk = k; mc = c; mop = op; mrd = rd; mrs = rs; mrq = rq; mwr = wr;
      end else if (m_hold) begin
         if (kbad) begin
            if (drops != 16'hFFFF) drops++;
            m_hold = 0;
         end else if (exp_iv) begin
            if (ir) begin
               m_hold = 0;
               if (mwr) npend[mrd] = 1'b1;
               busy_end = cyc + latency(mk, mop);
            end else begin
               m_offered = 1;
            end
         end else if (!cok) begin
            if (drops != 16'hFFFF) drops++;
            m_hold = 0;
         end
      end
      pend = npend;
      cyc++;
   endtask

   task automatic idle_n(input int n, input logic ir, input logic eq);
      for (int i = 0; i < n; i++)
         step(0, 0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, eq, 1'b0, 1'b0, 5'd0, ir);
   endtask

   task automatic wb(input logic [4:0] r);
      step(0, 0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, r, 1'b1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 0; in_kind = 0; in_cond = 0; in_op = 0; in_rd = 0; in_rs = 0;
      in_rq = 0; in_wr = 0; flag_eq = 0; flag_lt = 0; wb_valid = 0; wb_rd = 0; iss_ready = 0;
      step(1, 0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
      step(1, 1, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1);
      // ADD r3 <= r1,r2 then dependent SUB released by writeback of r3
      step(0, 1, 3'd0, 3'd0, 5'd0, 5'd3, 5'd1, 5'd2, 1, 0, 0, 0, 5'd0, 1);
      idle_n(2, 1, 0);
      step(0, 1, 3'd0, 3'd0, 5'd1, 5'd4, 5'd3, 5'd2, 1, 0, 0, 0, 5'd0, 1);
      idle_n(3, 1, 0);
      wb(5'd3);
      idle_n(2, 1, 0);
      // MUL and DIV occupancy
      step(0, 1, 3'd0, 3'd0, 5'd2, 5'd5, 5'd1, 5'd2, 1, 0, 0, 0, 5'd0, 1);
      idle_n(5, 1, 0);
      step(0, 1, 3'd1, 3'd0, 5'd3, 5'd6, 5'd1, 5'd2, 1, 0, 0, 0, 5'd0, 1);
      idle_n(18, 1, 0);
      // GT with eq set, then invalid kind
      step(0, 1, 3'd0, 3'd3, 5'd0, 5'd9, 5'd1, 5'd2, 1, 1, 0, 0, 5'd0, 1);
      idle_n(2, 1, 1);
      step(0, 1, 3'd7, 3'd0, 5'd0, 5'd9, 5'd1, 5'd2, 1, 0, 0, 0, 5'd0, 1);
      idle_n(2, 1, 0);
      // back-pressure for five cycles while flags change
      step(0, 1, 3'd0, 3'd1, 5'd0, 5'd8, 5'd1, 5'd2, 1, 1, 0, 0, 5'd0, 0);
      step(0, 0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 5'd0, 0);
      idle_n(4, 0, 0);
      idle_n(2, 1, 0);
      // issue and writeback of r7 in the same cycle
      step(0, 1, 3'd0, 3'd0, 5'd0, 5'd7, 5'd10, 5'd10, 1, 0, 0, 0, 5'd0, 1);
      step(0, 0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd7, 1);
      idle_n(2, 1, 0);
      // reset in the middle of a DIV
      step(0, 1, 3'd0, 3'd0, 5'd4, 5'd11, 5'd10, 5'd10, 1, 0, 0, 0, 5'd0, 1);
      idle_n(4, 1, 0);
      step(1, 0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1);
      idle_n(2, 1, 0);
      for (int n = 0; n < 4000; n++) begin
         logic [2:0] k;
         k = ($urandom % 16 < 12) ? 3'($urandom % 2) : 3'($urandom % 8);
         step(($urandom % 400) == 0, ($urandom % 10) < 7, k,
              ($urandom % 4 == 0) ? 3'($urandom % 8) : 3'd0, 5'($urandom % 6),
              5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8), ($urandom % 4) != 0,
              1'($urandom), 1'($urandom), ($urandom % 3) == 0, 5'($urandom % 8),
              ($urandom % 4) != 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/issue_sched.md
ISSUE_SCHED -- requirements
Module: issue_sched

Interface
REQ-001 Parameter MUL_LAT, default 3, total execute cycles for BINOP_MUL (range 1..255).
REQ-002 Parameter DIV_LAT, default 16, total execute cycles for BINOP_DIV and BINOP_MOD (range 1..255).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  decoded instruction present; in_ready  out  1  scheduler can accept.
REQ-006 in_kind  in  3  e_kind; in_cond  in  3  e_cond; in_op  in  5  e_bin_op/e_mem_op code.
REQ-007 in_rd, in_rs, in_rq  in  5 each  register indices; in_wr  in  1  instruction writes rd.
REQ-008 flag_eq, flag_lt  in  1 each  current compare flags (signed less-than).
REQ-009 wb_valid  in  1, wb_rd  in  5  writeback completion of register wb_rd.
REQ-010 iss_valid  out  1, iss_ready  in  1  issue handshake to execute stage; iss_kind/iss_op/iss_rd/iss_rs/iss_rq/iss_wr  out  held-instruction fields.
REQ-011 busy  out  1  multi-cycle op executing; err  out  1  one-cycle invalid-kind pulse.
REQ-012 sb  out  32  scoreboard, bit n = register n has pending write.
REQ-013 drop_cnt  out  16  count of condition-failed or invalid instructions, saturating.

Function
REQ-014 FSM states IDLE, HOLD, MULTI; in_ready SHALL equal (state==IDLE) and not rst.
REQ-015 IDLE: in_valid&&in_ready captures all in_* fields into hold register, next state HOLD.
REQ-016 HOLD, in_kind==KIND_INVALID or unused code (4..6 other than KIND_CUSTOM): err=1 one cycle, drop_cnt+1, next IDLE, no issue.
REQ-017 HOLD condition evaluated on flags that cycle: AL=1, EQ=eq, NE=!eq, GT=!eq&&!lt, GE=!lt, LT=lt, LE=lt||eq, NV=0.
REQ-018 HOLD, condition false: drop_cnt+1, next IDLE, no issue, scoreboard unchanged.
REQ-019 HOLD, hazard when sb[rs]|sb[rq]|(in_wr&&sb[rd]) of held fields: iss_valid=0, remain HOLD.
REQ-020 HOLD, no hazard, condition true: iss_valid=1; iss_* fields SHALL stay stable until iss_valid&&iss_ready.
REQ-021 Once iss_valid asserts it SHALL not deassert before handshake; condition/hazard not re-evaluated.
REQ-022 On handshake: if held wr, set sb[rd]; if kind RRR/RRI and op MUL, load counter MUL_LAT-1; DIV/MOD load DIV_LAT-1; counter 0 or any other op -> IDLE, else -> MULTI.
REQ-023 MULTI: busy=1, counter decrements each cycle, at counter==1 next IDLE (total MUL_LAT/DIV_LAT cycles including handshake cycle).
REQ-024 wb_valid clears sb[wb_rd] next edge; clear of a zero bit has no effect.
REQ-025 Same-cycle set (handshake) and clear of the same register: set wins.
REQ-026 drop_cnt SHALL saturate at 16'hFFFF, no wrap.
REQ-027 Minimum spacing between accepted instructions: two cycles (IDLE, HOLD).

Reset
REQ-028 rst assertion asynchronously forces state IDLE, counter 0, sb=0, drop_cnt=0, hold register 0.
REQ-029 During rst: in_ready=0, iss_valid=0, busy=0, err=0; mid-operation instruction (HOLD or MULTI) is discarded without issue.
REQ-030 First cycle after rst deassertion in_ready=1.

Configuration
REQ-031 Macro ISSUE_SCHED_WB_BYPASS_EN defined: hazard check in HOLD uses sb with the current-cycle wb_valid/wb_rd bit already cleared, allowing issue in the writeback cycle.
REQ-032 Macro undefined: hazard check uses registered sb only; issue no earlier than one cycle after writeback.

Verification
REQ-033 ADD rd=3 rs=1 rq=2 cond AL, iss_ready=1 -> iss_valid cycle 2 after accept, sb[3]=1, back to IDLE next cycle.
REQ-034 Then SUB rs=3 with sb[3]=1; wb_valid rd=3 at cycle N -> issue at N (bypass EN) or N+1 (not EN).
REQ-035 MUL, MUL_LAT=3, iss_ready=1 -> busy high 2 cycles, in_ready low until third cycle after handshake; DIV with DIV_LAT=16 -> busy 15 cycles.
REQ-036 cond GT with flag_eq=1 -> no iss_valid, drop_cnt 0->1; in_kind=3'b111 -> err pulse 1 cycle, drop_cnt+1.
REQ-037 iss_ready held 0 for 5 cycles -> iss_valid and iss_* stable all 5 cycles; rst pulsed in MULTI -> busy=0, sb=0, in_ready=1 after release.
REQ-038 Same-cycle handshake with wr rd=7 and wb_valid rd=7 -> sb[7]=1 afterwards.
